// File: rtl/xadc_seq_pkg.sv
// xadc_seq_pkg: shared types and constants for the XADC DRP sequencer.
//   seq_state_t : sequencer FSM states
//   VAUX*       : DRP addresses of the auxiliary channels in use
//   DATA_W_DEF  : default DRP data width
package xadc_seq_pkg;
   typedef enum logic [2:0] {IDLE, WAIT_EOC, ISSUE, WAIT_DRDY, STORE} seq_state_t;
   localparam logic [6:0] VAUX7  = 7'h17;
   localparam logic [6:0] VAUX14 = 7'h1E;
   localparam logic [6:0] VAUX15 = 7'h1F;
   localparam int DATA_W_DEF = 16;
endpackage

// File: rtl/xseq_chan_store.sv
// xseq_chan_store: result register for one sequenced channel.
//   CLK_100MHz : system clock
//   SW3_RST    : asynchronous active-high reset, clears result and history
//   wr_en      : one-cycle write strobe for a new sample
//   din        : new sample
//   dout       : latest sample, or the 4-sample average when XSEQ_AVG4_EN is defined
// Build option XSEQ_AVG4_EN: keep a 4-deep history and output (sum of last 4) >> 2.
module xseq_chan_store
   import xadc_seq_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              CLK_100MHz,
   input  logic              SW3_RST,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);
`ifdef XSEQ_AVG4_EN
   logic [DATA_W-1:0] h0, h1, h2;
   logic [DATA_W+1:0] sum;
   // The new sample plus the three before it; reset zeros count until filled.
   assign sum = {2'b00, din} + {2'b00, h0} + {2'b00, h1} + {2'b00, h2};
   always_ff @(posedge CLK_100MHz or posedge SW3_RST)
      if (SW3_RST) begin
         h0   <= '0;
         h1   <= '0;
         h2   <= '0;
         dout <= '0;
      end else if (wr_en) begin
         h0   <= din;
         h1   <= h0;
         h2   <= h1;
         dout <= sum[DATA_W+1:2];
      end
`else
   always_ff @(posedge CLK_100MHz or posedge SW3_RST)
      if (SW3_RST) dout <= '0;
      else if (wr_en) dout <= din;
`endif
endmodule

// File: rtl/xadc_drp_sequencer.sv
// xadc_drp_sequencer: walks a DRP channel table on each XADC EOC and keeps per-channel results.
//   CLK_100MHz  : system clock
//   SW3_RST     : asynchronous active-high reset
//   enable      : sequencing enable (level)
//   eoc_in      : XADC end-of-conversion pulse
//   drdy_in     : XADC DRP data ready
//   do_in       : XADC DRP read data
//   den_out     : one-cycle DRP enable
//   daddr_out   : DRP address, held until the next read
//   ch_data     : per-channel results, channel 0 in LSBs
//   ch_idx      : channel currently being read
//   frame_valid : one-cycle pulse after the last channel of a frame is stored
//   diff_out    : ch[DIFF_POS] - ch[DIFF_NEG], floored at 0
//   timeout_err : sticky, DRDY did not arrive within TIMEOUT cycles
//   overrun_err : sticky, EOC arrived while a read was in progress
// Build option XSEQ_AVG4_EN: channel results are 4-sample averages.
module xadc_drp_sequencer
   import xadc_seq_pkg::*;
#(
   parameter int               NCH      = 3,
   parameter int               DATA_W   = DATA_W_DEF,
   parameter logic [NCH*7-1:0] CH_ADDR  = {VAUX15, VAUX14, VAUX7},
   parameter int               DIFF_POS = 0,
   parameter int               DIFF_NEG = 2,
   parameter int               TIMEOUT  = 63,
   localparam int              IW       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                  CLK_100MHz,
   input  logic                  SW3_RST,
   input  logic                  enable,
   input  logic                  eoc_in,
   input  logic                  drdy_in,
   input  logic [DATA_W-1:0]     do_in,
   output logic                  den_out,
   output logic [6:0]            daddr_out,
   output logic [NCH*DATA_W-1:0] ch_data,
   output logic [IW-1:0]         ch_idx,
   output logic                  frame_valid,
   output logic [DATA_W-1:0]     diff_out,
   output logic                  timeout_err,
   output logic                  overrun_err
);
   localparam int TW = $clog2(TIMEOUT + 1);
   seq_state_t state, state_n;
   logic [TW-1:0] timer;
   logic [DATA_W-1:0] hold;
   logic captured, last, tmo_hit, busy;
   logic [DATA_W-1:0] pos, neg;
   assign last    = ch_idx == IW'(NCH - 1);
   // Abort on the TIMEOUT-th cycle after DEN unless DRDY shows up in that same cycle.
   assign tmo_hit = state == WAIT_DRDY && !drdy_in && timer == TW'(TIMEOUT - 1);
   assign busy    = state == ISSUE || state == WAIT_DRDY || state == STORE;
   assign den_out = state == ISSUE;
   always_ff @(posedge CLK_100MHz or posedge SW3_RST)
      if (SW3_RST) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:      state_n = enable ? WAIT_EOC : IDLE;
         WAIT_EOC:  state_n = !enable ? IDLE : eoc_in ? ISSUE : WAIT_EOC;
         ISSUE:     state_n = WAIT_DRDY;
         WAIT_DRDY: state_n = (drdy_in || tmo_hit) ? STORE : WAIT_DRDY;
         STORE:     state_n = enable ? WAIT_EOC : IDLE;
         default:   state_n = IDLE;
      endcase
   end
   always_ff @(posedge CLK_100MHz or posedge SW3_RST)
      if (SW3_RST) begin
         ch_idx      <= '0;
         daddr_out   <= CH_ADDR[6:0];
         timer       <= '0;
         hold        <= '0;
         captured    <= 1'b0;
         frame_valid <= 1'b0;
         timeout_err <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         frame_valid <= state == STORE && last;
         timer       <= (state == WAIT_DRDY) ? timer + TW'(1) : '0;
         if (state == IDLE) ch_idx <= '0;
         if (state == STORE) ch_idx <= last ? '0 : ch_idx + IW'(1);
         // Address is loaded on the way into ISSUE so it is valid alongside DEN.
         if (state == WAIT_EOC && state_n == ISSUE) daddr_out <= CH_ADDR[int'(ch_idx)*7 +: 7];
         if (state == ISSUE) captured <= 1'b0;
         if (state == WAIT_DRDY && drdy_in) begin
            hold     <= do_in;
            captured <= 1'b1;
         end
         if (tmo_hit) timeout_err <= 1'b1;
         if (eoc_in && busy) overrun_err <= 1'b1;
      end
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      xseq_chan_store #(.DATA_W(DATA_W)) u_store (
         .CLK_100MHz (CLK_100MHz),
         .SW3_RST    (SW3_RST),
         .wr_en      (state == STORE && captured && ch_idx == IW'(i)),
         .din        (hold),
         .dout       (ch_data[i*DATA_W +: DATA_W])
      );
   end
   assign pos = ch_data[DIFF_POS*DATA_W +: DATA_W];
   assign neg = ch_data[DIFF_NEG*DATA_W +: DATA_W];
   always_ff @(posedge CLK_100MHz or posedge SW3_RST)
      if (SW3_RST) diff_out <= '0;
      else diff_out <= (pos >= neg) ? pos - neg : '0;
endmodule
